// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU issue controller: ALU op codes
//            and the controller state type.
// Ports    : none (package)
// Config   : ALU_ISSUE_FLAGS_EN is consumed by the interface and top module.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl_if
// Purpose  : Bundles the load channel, command channel, ALU drive/return
//            signals and result outputs of the ALU issue controller.
// Modports : slave  - the controller (alu_issue_ctrl)
//            master - the environment (command source + ALU)
// Config   : ALU_ISSUE_FLAGS_EN adds res_zero / res_neg.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8
);
   localparam int ADDR_W = $clog2(NREGS);

   // register load channel
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   // ALU command channel
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_rd;
   logic [ADDR_W-1:0] cmd_rs1;
   logic [ADDR_W-1:0] cmd_rs2;
   // ALU drive and return
   logic [1:0]        alu_op;
   logic [DATA_W-1:0] alu_i0;
   logic [DATA_W-1:0] alu_i1;
   logic [DATA_W-1:0] alu_o;
   logic              alu_cout;
   // result
   logic              res_valid;
   logic [DATA_W-1:0] res_data;
   logic              res_cout;
`ifdef ALU_ISSUE_FLAGS_EN
   logic              res_zero;
   logic              res_neg;
`endif

   modport slave (
`ifdef ALU_ISSUE_FLAGS_EN
      output res_zero, res_neg,
`endif
      input  ld_valid, ld_addr, ld_data,
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
      input  alu_o, alu_cout,
      output ld_ready, cmd_ready,
      output alu_op, alu_i0, alu_i1,
      output res_valid, res_data, res_cout
   );

   modport master (
`ifdef ALU_ISSUE_FLAGS_EN
      input  res_zero, res_neg,
`endif
      output ld_valid, ld_addr, ld_data,
      output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
      output alu_o, alu_cout,
      input  ld_ready, cmd_ready,
      input  alu_op, alu_i0, alu_i1,
      input  res_valid, res_data, res_cout
   );

endinterface
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_regfile
// Purpose  : NREGS x DATA_W operand register file, two asynchronous read
//            ports and one synchronous write port, synchronous reset to 0.
// Ports    : clk, reset            - clock / sync active-high reset
//            i_we, i_waddr, i_wdata - write port
//            i_raddr0 -> o_rdata0   - read port 0
//            i_raddr1 -> o_rdata1   - read port 1
// Revision : 1.0 - initial release
// ============================================================================
module alu_regfile #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8,
   parameter int ADDR_W = $clog2(NREGS)
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              i_we,
   input  wire logic [ADDR_W-1:0] i_waddr,
   input  wire logic [DATA_W-1:0] i_wdata,
   input  wire logic [ADDR_W-1:0] i_raddr0,
   output logic      [DATA_W-1:0] o_rdata0,
   input  wire logic [ADDR_W-1:0] i_raddr1,
   output logic      [DATA_W-1:0] o_rdata1
);

   logic [DATA_W-1:0] r_mem [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Reads are combinational, so a read in the cycle after a write already
   // returns the written value without any bypass path.
   assign o_rdata0 = r_mem[i_raddr0];
   assign o_rdata1 = r_mem[i_raddr1];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Upstream feeder for a 16-bit two-operand ALU. Holds an operand
//            register file, accepts register loads and register-addressed
//            ALU commands, drives registered op/i0/i1 to the ALU and writes
//            the ALU result back one cycle later.
// Ports    : clk   - clock, all state updates on posedge
//            reset - synchronous, active-high
//            bus   - alu_issue_ctrl_if.slave (load, command, ALU, result)
// Config   : ALU_ISSUE_FLAGS_EN adds registered res_zero / res_neg outputs.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8
) (
   input  wire logic       clk,
   input  wire logic       reset,
   alu_issue_ctrl_if.slave bus
);

   localparam int ADDR_W = $clog2(NREGS);

   state_t            r_state;
   state_t            w_state_next;

   logic              w_ld_ready;
   logic              w_cmd_ready;
   logic              w_ld_fire;
   logic              w_cmd_fire;
   logic              w_wb;

   logic              w_rf_we;
   logic [ADDR_W-1:0] w_rf_waddr;
   logic [DATA_W-1:0] w_rf_wdata;
   logic [DATA_W-1:0] w_rs1_data;
   logic [DATA_W-1:0] w_rs2_data;

   logic [1:0]        r_alu_op;
   logic [DATA_W-1:0] r_alu_i0;
   logic [DATA_W-1:0] r_alu_i1;
   logic [ADDR_W-1:0] r_rd;
   logic              r_res_valid;
   logic [DATA_W-1:0] r_res_data;
   logic              r_res_cout;
`ifdef ALU_ISSUE_FLAGS_EN
   logic              r_res_zero;
   logic              r_res_neg;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ld_ready   = 1'b0;
      w_cmd_ready  = 1'b0;
      w_ld_fire    = 1'b0;
      w_cmd_fire   = 1'b0;
      w_wb         = 1'b0;
      case (r_state)
         IDLE: begin
            w_ld_ready  = 1'b1;
            // A pending load always takes the cycle; the command waits.
            w_cmd_ready = ~bus.ld_valid;
            w_ld_fire   = bus.ld_valid;
            w_cmd_fire  = bus.cmd_valid & ~bus.ld_valid;
            if (w_cmd_fire) begin
               w_state_next = EXEC;
            end
         end
         EXEC: begin
            w_wb         = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign bus.ld_ready  = w_ld_ready;
   assign bus.cmd_ready = w_cmd_ready;

   // ---------------------------------------------------------- reg file
   // Loads only happen in IDLE and writeback only in EXEC, so the single
   // write port is never contended.
   assign w_rf_we    = w_ld_fire | w_wb;
   assign w_rf_waddr = w_wb ? r_rd      : bus.ld_addr;
   assign w_rf_wdata = w_wb ? bus.alu_o : bus.ld_data;

   alu_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W)
   ) u_rf (
      .clk      (clk),
      .reset    (reset),
      .i_we     (w_rf_we),
      .i_waddr  (w_rf_waddr),
      .i_wdata  (w_rf_wdata),
      .i_raddr0 (bus.cmd_rs1),
      .o_rdata0 (w_rs1_data),
      .i_raddr1 (bus.cmd_rs2),
      .o_rdata1 (w_rs2_data)
   );

   // ----------------------------------------------- operand/result regs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_alu_op    <= '0;
         r_alu_i0    <= '0;
         r_alu_i1    <= '0;
         r_rd        <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_cout  <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
         r_res_zero  <= 1'b0;
         r_res_neg   <= 1'b0;
`endif
      end else begin
         // Operands are captured at accept so the ALU sees pre-op values
         // even when rd aliases a source.
         if (w_cmd_fire) begin
            r_alu_op <= bus.cmd_op;
            r_alu_i0 <= w_rs1_data;
            r_alu_i1 <= w_rs2_data;
            r_rd     <= bus.cmd_rd;
         end
         r_res_valid <= w_wb;
         if (w_wb) begin
            r_res_data <= bus.alu_o;
            r_res_cout <= bus.alu_cout;
`ifdef ALU_ISSUE_FLAGS_EN
            r_res_zero <= (bus.alu_o == '0);
            r_res_neg  <= bus.alu_o[DATA_W-1];
`endif
         end
      end
   end

   assign bus.alu_op    = r_alu_op;
   assign bus.alu_i0    = r_alu_i0;
   assign bus.alu_i1    = r_alu_i1;
   assign bus.res_valid = r_res_valid;
   assign bus.res_data  = r_res_data;
   assign bus.res_cout  = r_res_cout;
`ifdef ALU_ISSUE_FLAGS_EN
   assign bus.res_zero  = r_res_zero;
   assign bus.res_neg   = r_res_neg;
`endif

endmodule
`default_nettype wire
